// File: rtl/uart_boot_loader_if.sv
// Byte-side UART signals and word-side DMA port of the boot loader.
// The master modport is the loader; the slave modport is its environment.
interface uart_boot_loader_if;
   logic        rx_ready;
   logic [7:0]  rdata;
   logic        tx_busy;
   logic        tx_start;
   logic [7:0]  sdata;
   logic        instr_ready;
   logic        mem_ready;
   logic [31:0] data;
   logic        program_loaded;

   modport master (
      input  rx_ready, rdata, tx_busy,
      output tx_start, sdata, instr_ready, mem_ready, data, program_loaded
   );

   modport slave (
      output rx_ready, rdata, tx_busy,
      input  tx_start, sdata, instr_ready, mem_ready, data, program_loaded
   );
endinterface

// File: rtl/uart_boot_loader.sv
// Assembles UART bytes into little-endian words: a count word, then that many
// instruction words, a one-byte load acknowledge, then input-data words forever.
module uart_boot_loader #(
   parameter int unsigned MAX_INSTR = 256,
   parameter logic [7:0]  ACK_BYTE  = 8'hAA
) (
   input logic             clock,
   input logic             reset,
   uart_boot_loader_if.master bus
);
   typedef enum logic [1:0] {S_SIZE, S_INSTR, S_ACK, S_DATA} state_t;

   state_t      state_reg, state_next;
   logic [1:0]  byte_idx_reg, byte_idx_next;
   logic [23:0] shift_reg, shift_next;
   logic [31:0] data_reg, data_next;
   logic [31:0] remaining_reg, remaining_next;
   logic [31:0] emitted_reg, emitted_next;
   logic        instr_ready_reg, instr_ready_next;
   logic        mem_ready_reg, mem_ready_next;
   logic        tx_start_reg, tx_start_next;
   logic [7:0]  sdata_reg, sdata_next;
   logic        word_done;
   logic [31:0] word;

   // Earlier bytes sit in shift_reg with byte 0 lowest once three have arrived.
   assign word = {bus.rdata, shift_reg};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg       <= S_SIZE;
         byte_idx_reg    <= 2'd0;
         shift_reg       <= 24'd0;
         data_reg        <= 32'd0;
         remaining_reg   <= 32'd0;
         emitted_reg     <= 32'd0;
         instr_ready_reg <= 1'b0;
         mem_ready_reg   <= 1'b0;
         tx_start_reg    <= 1'b0;
         sdata_reg       <= 8'd0;
      end else begin
         state_reg       <= state_next;
         byte_idx_reg    <= byte_idx_next;
         shift_reg       <= shift_next;
         data_reg        <= data_next;
         remaining_reg   <= remaining_next;
         emitted_reg     <= emitted_next;
         instr_ready_reg <= instr_ready_next;
         mem_ready_reg   <= mem_ready_next;
         tx_start_reg    <= tx_start_next;
         sdata_reg       <= sdata_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      byte_idx_next    = byte_idx_reg;
      shift_next       = shift_reg;
      data_next        = data_reg;
      remaining_next   = remaining_reg;
      emitted_next     = emitted_reg;
      instr_ready_next = 1'b0;
      mem_ready_next   = 1'b0;
      tx_start_next    = 1'b0;
      sdata_next       = sdata_reg;
      word_done        = 1'b0;

      if (bus.rx_ready) begin
         if (byte_idx_reg == 2'd3) begin
            word_done     = 1'b1;
            data_next     = word;
            byte_idx_next = 2'd0;
         end else begin
            shift_next    = {bus.rdata, shift_reg[23:8]};
            byte_idx_next = byte_idx_reg + 2'd1;
         end
      end

      case (state_reg)
         S_SIZE: begin
            if (word_done) begin
               remaining_next = word;
               emitted_next   = 32'd0;
               state_next     = (word == 32'd0) ? S_ACK : S_INSTR;
            end
         end
         S_INSTR: begin
            if (word_done) begin
               remaining_next = remaining_reg - 32'd1;
               // Words past the code segment capacity are swallowed.
               if (emitted_reg < MAX_INSTR) begin
                  instr_ready_next = 1'b1;
                  emitted_next     = emitted_reg + 32'd1;
               end
               if (remaining_reg == 32'd1) begin
                  state_next = S_ACK;
               end
            end
         end
         S_ACK: begin
            mem_ready_next = word_done;
            if (!bus.tx_busy) begin
               tx_start_next = 1'b1;
               sdata_next    = ACK_BYTE;
               state_next    = S_DATA;
            end
         end
         S_DATA: begin
            mem_ready_next = word_done;
         end
         default: begin
            state_next = S_SIZE;
         end
      endcase
   end

   assign bus.tx_start       = tx_start_reg;
   assign bus.sdata          = sdata_reg;
   assign bus.instr_ready    = instr_ready_reg;
   assign bus.mem_ready      = mem_ready_reg;
   assign bus.data           = data_reg;
   assign bus.program_loaded = (state_reg == S_DATA);
endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench: two loaders (code capacity 256 and 4) share one byte stream
// and are compared every cycle against a word-index reference model.
module tb_uart_boot_loader;
   logic       clock = 1'b0;
   logic       reset;
   logic       rx_ready = 1'b0;
   logic [7:0] rdata = 8'd0;
   logic       tx_busy = 1'b0;

   int unsigned errors = 0;
   int unsigned checks = 0;
   bit          mon_en = 1'b0;

   uart_boot_loader_if bus0 ();
   uart_boot_loader_if bus1 ();

   assign bus0.rx_ready = rx_ready;
   assign bus0.rdata    = rdata;
   assign bus0.tx_busy  = tx_busy;
   assign bus1.rx_ready = rx_ready;
   assign bus1.rdata    = rdata;
   assign bus1.tx_busy  = tx_busy;

   uart_boot_loader #(.MAX_INSTR(256), .ACK_BYTE(8'hAA)) dut0 (
      .clock(clock), .reset(reset), .bus(bus0.master));
   uart_boot_loader #(.MAX_INSTR(4), .ACK_BYTE(8'hAA)) dut1 (
      .clock(clock), .reset(reset), .bus(bus1.master));

   always #5 clock = ~clock;

   task automatic chk(input string name, input int unsigned inst,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[dut%0d]: got %h expected %h", name, inst, act, exp);
      end
   endtask

   // Reference model: classify each completed word by its index since reset.
   int unsigned     maxv [2] = '{256, 4};
   logic [31:0]     m_part [2];
   int              m_nb [2];
   longint unsigned m_k [2];
   longint unsigned m_n [2];
   bit              m_pend [2];
   bit              m_acked [2];
   bit              e_instr [2];
   bit              e_mem [2];
   bit              e_tx [2];
   logic [31:0]     e_data [2];

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         m_part[i] = 0; m_nb[i] = 0; m_k[i] = 0; m_n[i] = 0;
         m_pend[i] = 0; m_acked[i] = 0;
         e_instr[i] = 0; e_mem[i] = 0; e_tx[i] = 0; e_data[i] = 0;
      end
   endtask

   task automatic model_step();
      logic [31:0] w;
      for (int i = 0; i < 2; i++) begin
         e_instr[i] = 0; e_mem[i] = 0; e_tx[i] = 0;
         if (m_pend[i] && !tx_busy) begin
            e_tx[i] = 1; m_acked[i] = 1; m_pend[i] = 0;
         end
         if (rx_ready) begin
            m_part[i] = m_part[i] | (32'(rdata) << (8 * m_nb[i]));
            m_nb[i]++;
            if (m_nb[i] == 4) begin
               w = m_part[i];
               m_part[i] = 0; m_nb[i] = 0;
               e_data[i] = w;
               if (m_k[i] == 0) begin
                  m_n[i] = longint'(w);
                  if (w == 0) m_pend[i] = 1;
               end else if (m_k[i] <= m_n[i]) begin
                  if (m_k[i] <= longint'(maxv[i])) e_instr[i] = 1;
                  if (m_k[i] == m_n[i]) m_pend[i] = 1;
               end else begin
                  e_mem[i] = 1;
               end
               m_k[i]++;
            end
         end
      end
   endtask

   initial forever begin
      @(negedge reset);
      model_clear();
   end

   initial forever begin
      @(posedge clock);
      if (!reset) model_clear();
      else model_step();
   end

   int unsigned instr_cnt [2];
   int unsigned mem_cnt [2];
   int unsigned tx_cnt [2];

   task automatic clr_counts();
      for (int i = 0; i < 2; i++) begin
         instr_cnt[i] = 0; mem_cnt[i] = 0; tx_cnt[i] = 0;
      end
   endtask

   task automatic check_inst(input int unsigned i, input logic ir, input logic mr,
                             input logic ts, input logic [7:0] sd,
                             input logic [31:0] d, input logic pl);
      chk("instr_ready", i, 32'(ir), 32'(e_instr[i]));
      chk("mem_ready", i, 32'(mr), 32'(e_mem[i]));
      chk("tx_start", i, 32'(ts), 32'(e_tx[i]));
      chk("sdata", i, 32'(sd), m_acked[i] ? 32'hAA : 32'h0);
      chk("data", i, d, e_data[i]);
      chk("program_loaded", i, 32'(pl), 32'(m_acked[i]));
      if (ir === 1'b1) instr_cnt[i]++;
      if (mr === 1'b1) mem_cnt[i]++;
      if (ts === 1'b1) tx_cnt[i]++;
   endtask

   initial forever begin
      @(negedge clock);
      if (mon_en) begin
         check_inst(0, bus0.instr_ready, bus0.mem_ready, bus0.tx_start, bus0.sdata,
                    bus0.data, bus0.program_loaded);
         check_inst(1, bus1.instr_ready, bus1.mem_ready, bus1.tx_start, bus1.sdata,
                    bus1.data, bus1.program_loaded);
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, ".tx_start"}, 0, 32'(bus0.tx_start), 0);
      chk({tag, ".sdata"}, 0, 32'(bus0.sdata), 0);
      chk({tag, ".instr_ready"}, 0, 32'(bus0.instr_ready), 0);
      chk({tag, ".mem_ready"}, 0, 32'(bus0.mem_ready), 0);
      chk({tag, ".data"}, 0, bus0.data, 0);
      chk({tag, ".program_loaded"}, 0, 32'(bus0.program_loaded), 0);
      chk({tag, ".data"}, 1, bus1.data, 0);
      chk({tag, ".program_loaded"}, 1, 32'(bus1.program_loaded), 0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_ready = 1'b1;
      rdata    = b;
      @(negedge clock);
      rx_ready = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int j = 0; j < 4; j++) send_byte(8'(w >> (8 * j)));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      clr_counts();
   endtask

   typedef struct {
      logic        rx;
      logic [7:0]  b;
      logic        busy;
      logic        ei;
      logic        em;
      logic        et;
      logic        el;
      logic [31:0] ed;
   } vec_t;

   function automatic vec_t mk(input logic rx, input logic [7:0] b, input logic ei,
                               input logic et, input logic el, input logic [31:0] ed);
      vec_t v;
      v.rx = rx; v.b = b; v.busy = 1'b0;
      v.ei = ei; v.em = 1'b0; v.et = et; v.el = el; v.ed = ed;
      return v;
   endfunction

   vec_t tbl [14];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = mk(1, 8'h02, 0, 0, 0, 32'h0);
      tbl[1]  = mk(1, 8'h00, 0, 0, 0, 32'h0);
      tbl[2]  = mk(1, 8'h00, 0, 0, 0, 32'h0);
      tbl[3]  = mk(1, 8'h00, 0, 0, 0, 32'h2);
      tbl[4]  = mk(1, 8'h78, 0, 0, 0, 32'h2);
      tbl[5]  = mk(1, 8'h56, 0, 0, 0, 32'h2);
      tbl[6]  = mk(1, 8'h34, 0, 0, 0, 32'h2);
      tbl[7]  = mk(1, 8'h12, 1, 0, 0, 32'h12345678);
      tbl[8]  = mk(1, 8'hEF, 0, 0, 0, 32'h12345678);
      tbl[9]  = mk(1, 8'hBE, 0, 0, 0, 32'h12345678);
      tbl[10] = mk(1, 8'hAD, 0, 0, 0, 32'h12345678);
      tbl[11] = mk(1, 8'hDE, 1, 0, 0, 32'hDEADBEEF);
      tbl[12] = mk(0, 8'h00, 0, 1, 1, 32'hDEADBEEF);
      tbl[13] = mk(0, 8'h00, 0, 0, 1, 32'hDEADBEEF);

      reset = 1'b0;
      repeat (2) @(negedge clock);
      check_zero("reset");
      $display("reset: outputs checked");
      reset = 1'b1;
      clr_counts();
      mon_en = 1'b1;

      // Basic load, table-driven against fixed expectations.
      for (int r = 0; r < 14; r++) begin
         rx_ready = tbl[r].rx;
         rdata    = tbl[r].b;
         tx_busy  = tbl[r].busy;
         @(negedge clock);
         rx_ready = 1'b0;
         chk("tbl.instr_ready", 0, 32'(bus0.instr_ready), 32'(tbl[r].ei));
         chk("tbl.mem_ready", 0, 32'(bus0.mem_ready), 32'(tbl[r].em));
         chk("tbl.tx_start", 0, 32'(bus0.tx_start), 32'(tbl[r].et));
         chk("tbl.program_loaded", 0, 32'(bus0.program_loaded), 32'(tbl[r].el));
         chk("tbl.data", 0, bus0.data, tbl[r].ed);
         $display("basic row %0d: rx=%0b byte=%h data=%h", r, tbl[r].rx, tbl[r].b, bus0.data);
      end
      chk("basic.sdata", 0, 32'(bus0.sdata), 32'hAA);

      // Empty program with the transmitter busy for ten cycles.
      do_reset();
      tx_busy = 1'b1;
      send_word(32'h0);
      idle(6);
      chk("empty.tx_held", 0, 32'(bus0.tx_start), 0);
      tx_busy = 1'b0;
      @(negedge clock);
      chk("empty.tx_start", 0, 32'(bus0.tx_start), 1);
      @(negedge clock);
      chk("empty.tx_single", 0, 32'(bus0.tx_start), 0);
      send_word(32'h1);
      chk("empty.mem_ready", 0, 32'(bus0.mem_ready), 1);
      chk("empty.data", 0, bus0.data, 32'h1);
      chk("empty.instr_cnt", 0, instr_cnt[0], 0);
      $display("empty program: tx_cnt=%0d mem_cnt=%0d", tx_cnt[0], mem_cnt[0]);

      // Overflow: count 6, capacity 256 versus 4.
      do_reset();
      send_word(32'd6);
      for (int n = 0; n < 6; n++) send_word($urandom);
      idle(3);
      chk("ovf.instr_cnt", 0, instr_cnt[0], 6);
      chk("ovf.instr_cnt", 1, instr_cnt[1], 4);
      chk("ovf.mem_cnt", 1, mem_cnt[1], 0);
      chk("ovf.tx_cnt", 1, tx_cnt[1], 1);
      $display("overflow: instr dut0=%0d dut1=%0d", instr_cnt[0], instr_cnt[1]);

      // Overlap: a data word arrives while the acknowledge waits on tx_busy.
      do_reset();
      tx_busy = 1'b1;
      send_word(32'd1);
      send_word(32'hCAFEF00D);
      send_word(32'h0BADC0DE);
      idle(2);
      tx_busy = 1'b0;
      idle(3);
      chk("ovl.mem_cnt", 0, mem_cnt[0], 1);
      chk("ovl.tx_cnt", 0, tx_cnt[0], 1);
      chk("ovl.data", 0, bus0.data, 32'h0BADC0DE);
      $display("overlap: mem_cnt=%0d tx_cnt=%0d", mem_cnt[0], tx_cnt[0]);

      // Asynchronous reset in the middle of a data word.
      send_byte(8'hAB);
      send_byte(8'hCD);
      #1 reset = 1'b0;
      #1 check_zero("async");
      #1 reset = 1'b1;
      clr_counts();
      @(negedge clock);
      send_word(32'd3);
      send_word(32'h11223344);
      chk("async.instr_cnt", 0, instr_cnt[0], 1);
      chk("async.data", 0, bus0.data, 32'h11223344);
      send_word($urandom);
      send_word($urandom);
      idle(2);
      chk("async.loaded", 0, 32'(bus0.program_loaded), 1);
      $display("async reset: instr_cnt=%0d tx_cnt=%0d", instr_cnt[0], tx_cnt[0]);

      // Streaming: 1000 random words back to back.
      clr_counts();
      for (int n = 0; n < 1000; n++) begin
         tx_busy = 1'($urandom);
         send_word($urandom);
      end
      tx_busy = 1'b0;
      idle(2);
      for (int i = 0; i < 2; i++) begin
         chk("stream.mem_cnt", i, mem_cnt[i], 1000);
         chk("stream.tx_cnt", i, tx_cnt[i], 0);
         chk("stream.instr_cnt", i, instr_cnt[i], 0);
      end
      $display("streaming: mem dut0=%0d dut1=%0d", mem_cnt[0], mem_cnt[1]);

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
